// File: rtl/ring_johnson_decoder.sv
// Ring/Johnson code decoder and sequence monitor with a lock/error state machine
// and a saturating error counter.
module ring_johnson_decoder #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned IDXW     = ($clog2(2 * WIDTH) < 1) ? 1 : $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] dinr,
  input  logic [WIDTH-1:0] dinj,
  output logic [IDXW-1:0]  ring_idx,
  output logic [IDXW-1:0]  john_idx,
  output logic             ring_ok,
  output logic             john_ok,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_cnt
);

  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   good, good_nx;
  logic [IDXW-1:0] prev_r, prev_j, prev_r_nx, prev_j_nx;
  logic            err_nx;

  logic [IDXW-1:0] r_cnt, r_pos, j_ones, j_zeros, j_pos;
  logic [WIDTH-1:0] j_ref;
  logic            r_legal, j_legal, both_legal, good_step;
  logic [IDXW-1:0] r_inc, j_inc;

  // Combinational decode of both code words
  always_comb begin
    r_cnt  = '0;
    r_pos  = '0;
    j_ones = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (dinr[i]) begin
        r_cnt = r_cnt + IDXW'(1);
        r_pos = IDXW'(i);
      end
      j_ones = j_ones + IDXW'(dinj[i]);
    end
    r_legal = (r_cnt == IDXW'(1));
    j_zeros = IDXW'(WIDTH) - j_ones;
    j_ref   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (dinj[WIDTH-1]) j_ref[i] = (IDXW'(i) >= j_zeros);
      else               j_ref[i] = (IDXW'(i) < j_ones);
    end
    j_legal = (dinj == j_ref);
    j_pos   = dinj[WIDTH-1] ? (IDXW'(WIDTH) + j_zeros) : j_ones;
  end

  // Expected successor of the stored indices, with wrap-around
  always_comb begin
    r_inc      = (prev_r == IDXW'(WIDTH - 1))     ? '0 : prev_r + IDXW'(1);
    j_inc      = (prev_j == IDXW'(2 * WIDTH - 1)) ? '0 : prev_j + IDXW'(1);
    both_legal = r_legal && j_legal;
    good_step  = both_legal && (r_pos == r_inc) && (j_pos == j_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    good_nx   = good;
    prev_r_nx = prev_r;
    prev_j_nx = prev_j;
    err_nx    = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          if (both_legal) begin
            prev_r_nx = r_pos;
            prev_j_nx = j_pos;
            good_nx   = '0;
            state_nx  = TRACK;
          end
        end
        TRACK: begin
          if (!both_legal) begin
            state_nx = HUNT;
          end else begin
            prev_r_nx = r_pos;
            prev_j_nx = j_pos;
            if (!good_step) begin
              good_nx = '0;
            end else begin
              good_nx = good + GW'(1);
              if (good + GW'(1) == GW'(LOCK_CNT)) state_nx = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (good_step) begin
            prev_r_nx = r_pos;
            prev_j_nx = j_pos;
          end else begin
            err_nx = 1'b1;
            if (!both_legal) begin
              state_nx = HUNT;
            end else begin
              good_nx   = '0;
              prev_r_nx = r_pos;
              prev_j_nx = j_pos;
              state_nx  = TRACK;
            end
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      good      <= '0;
      prev_r    <= '0;
      prev_j    <= '0;
      ring_idx  <= '0;
      john_idx  <= '0;
      ring_ok   <= 1'b0;
      john_ok   <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      good      <= good_nx;
      prev_r    <= prev_r_nx;
      prev_j    <= prev_j_nx;
      locked    <= (state_nx == LOCKED);
      err_pulse <= err_nx;
      if (en) begin
        ring_ok <= r_legal;
        john_ok <= j_legal;
        if (r_legal) ring_idx <= r_pos;
        if (j_legal) john_idx <= j_pos;
      end
      if (err_nx && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ring_johnson_decoder.sv
// Randomized and directed bench for ring_johnson_decoder against a table-driven model,
// covering WIDTH=2 and WIDTH=4 instances.
module tb_ring_johnson_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, en0, rst1, en1;
  logic [1:0] dinr0, dinj0, ridx0, jidx0;
  logic [3:0] dinr1, dinj1;
  logic [2:0] ridx1, jidx1;
  logic       rok0, jok0, lk0, ep0, rok1, jok1, lk1, ep1;
  logic [7:0] ec0, ec1;

  ring_johnson_decoder #(.WIDTH(2), .LOCK_CNT(3)) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .dinr(dinr0), .dinj(dinj0),
    .ring_idx(ridx0), .john_idx(jidx0), .ring_ok(rok0), .john_ok(jok0),
    .locked(lk0), .err_pulse(ep0), .err_cnt(ec0));

  ring_johnson_decoder #(.WIDTH(4), .LOCK_CNT(3)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .dinr(dinr1), .dinj(dinj1),
    .ring_idx(ridx1), .john_idx(jidx1), .ring_ok(rok1), .john_ok(jok1),
    .locked(lk1), .err_pulse(ep1), .err_cnt(ec1));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: decode by searching the legal code sequence for each width
  int wid[2];
  int m_ri[2], m_ji[2], m_rok[2], m_jok[2], m_mode[2], m_good[2];
  int m_pr[2], m_pj[2], m_ep[2], m_cnt[2];
  int s_r[2], s_j[2];

  function automatic int jcode(int k, int w);
    int c = 0;
    int mask = (1 << w) - 1;
    for (int s = 0; s < k; s++) c = ((c << 1) | (((c >> (w - 1)) & 1) ^ 1)) & mask;
    return c;
  endfunction

  function automatic int rdec(int code, int w);
    for (int k = 0; k < w; k++) if (code == (1 << k)) return k;
    return -1;
  endfunction

  function automatic int jdec(int code, int w);
    for (int k = 0; k < 2 * w; k++) if (code == jcode(k, w)) return k;
    return -1;
  endfunction

  task automatic model_step(input int id, input bit e, input int r, input int j, input bit rs);
    int w, ri, ji;
    bit both, gs;
    w = wid[id];
    if (rs) begin
      m_ri[id] = 0; m_ji[id] = 0; m_rok[id] = 0; m_jok[id] = 0; m_mode[id] = 0;
      m_good[id] = 0; m_pr[id] = 0; m_pj[id] = 0; m_ep[id] = 0; m_cnt[id] = 0;
    end else if (e) begin
      ri = rdec(r & ((1 << w) - 1), w);
      ji = jdec(j & ((1 << w) - 1), w);
      m_rok[id] = (ri >= 0);
      m_jok[id] = (ji >= 0);
      if (ri >= 0) m_ri[id] = ri;
      if (ji >= 0) m_ji[id] = ji;
      m_ep[id] = 0;
      both = (ri >= 0) && (ji >= 0);
      gs = both && (ri == (m_pr[id] + 1) % w) && (ji == (m_pj[id] + 1) % (2 * w));
      case (m_mode[id])
        0: if (both) begin m_pr[id] = ri; m_pj[id] = ji; m_good[id] = 0; m_mode[id] = 1; end
        1: begin
          if (!both) m_mode[id] = 0;
          else begin
            m_pr[id] = ri; m_pj[id] = ji;
            if (!gs) m_good[id] = 0;
            else begin
              m_good[id]++;
              if (m_good[id] == 3) m_mode[id] = 2;
            end
          end
        end
        default: begin
          if (gs) begin m_pr[id] = ri; m_pj[id] = ji; end
          else begin
            m_ep[id] = 1;
            if (m_cnt[id] < 255) m_cnt[id]++;
            if (!both) m_mode[id] = 0;
            else begin m_good[id] = 0; m_pr[id] = ri; m_pj[id] = ji; m_mode[id] = 1; end
          end
        end
      endcase
    end else begin
      m_ep[id] = 0;
    end
  endtask

  task automatic compare(input int id);
    if (id == 0) begin
      check("w2_ring_idx", 32'(ridx0), m_ri[0]);
      check("w2_john_idx", 32'(jidx0), m_ji[0]);
      check("w2_ring_ok", 32'(rok0), m_rok[0]);
      check("w2_john_ok", 32'(jok0), m_jok[0]);
      check("w2_locked", 32'(lk0), 32'(m_mode[0] == 2));
      check("w2_err_pulse", 32'(ep0), m_ep[0]);
      check("w2_err_cnt", 32'(ec0), m_cnt[0]);
    end else begin
      check("w4_ring_idx", 32'(ridx1), m_ri[1]);
      check("w4_john_idx", 32'(jidx1), m_ji[1]);
      check("w4_ring_ok", 32'(rok1), m_rok[1]);
      check("w4_john_ok", 32'(jok1), m_jok[1]);
      check("w4_locked", 32'(lk1), 32'(m_mode[1] == 2));
      check("w4_err_pulse", 32'(ep1), m_ep[1]);
      check("w4_err_cnt", 32'(ec1), m_cnt[1]);
    end
  endtask

  task automatic cycle(input int id, input bit e, input int r, input int j, input bit rs);
    if (id == 0) begin
      en0 = e; dinr0 = r[1:0]; dinj0 = j[1:0]; rst0 = rs; en1 = 1'b0; rst1 = 1'b0;
    end else begin
      en1 = e; dinr1 = r[3:0]; dinj1 = j[3:0]; rst1 = rs; en0 = 1'b0; rst0 = 1'b0;
    end
    @(posedge clk);
    model_step(id, e, r, j, rs);
    #1;
    compare(id);
  endtask

  task automatic good_step(input int id);
    s_r[id] = (s_r[id] + 1) % wid[id];
    s_j[id] = (s_j[id] + 1) % (2 * wid[id]);
    cycle(id, 1'b1, 1 << s_r[id], jcode(s_j[id], wid[id]), 1'b0);
  endtask

  task automatic repeat_code(input int id);
    cycle(id, 1'b1, 1 << s_r[id], jcode(s_j[id], wid[id]), 1'b0);
  endtask

  task automatic random_phase(input int id, input int n);
    int p, w;
    w = wid[id];
    for (int i = 0; i < n; i++) begin
      p = $urandom_range(99);
      if (p < 65) good_step(id);
      else if (p < 78) cycle(id, 1'b0, $urandom, $urandom, 1'b0);
      else if (p < 88) cycle(id, 1'b1, $urandom, $urandom, 1'b0);
      else if (p < 95) begin
        s_r[id] = $urandom_range(w - 1);
        s_j[id] = $urandom_range(2 * w - 1);
        repeat_code(id);
      end else if (p < 98) repeat_code(id);
      else cycle(id, 1'b1, $urandom, $urandom, 1'b1);
    end
  endtask

  initial begin
    wid[0] = 2; wid[1] = 4;
    en0 = 0; en1 = 0; rst0 = 0; rst1 = 0; dinr0 = 0; dinj0 = 0; dinr1 = 0; dinj1 = 0;
    repeat (2) @(posedge clk);

    // Reset state and basic acquisition at WIDTH=2
    cycle(0, 1'b0, 0, 0, 1'b1);
    check("reset_locked", 32'(lk0), 0);
    check("reset_err_cnt", 32'(ec0), 0);
    s_r[0] = 1; s_j[0] = 3;
    repeat (4) good_step(0);
    check("t1_locked", 32'(lk0), 1);
    check("t1_john_idx", 32'(jidx0), 3);
    check("t1_err_cnt", 32'(ec0), 0);

    // Johnson skip while locked
    good_step(0);
    s_r[0] = 1; s_j[0] = 2;
    repeat_code(0);
    check("t2_err_pulse", 32'(ep0), 1);
    check("t2_err_cnt", 32'(ec0), 1);
    check("t2_locked", 32'(lk0), 0);
    good_step(0);
    check("t2_pulse_one_cycle", 32'(ep0), 0);
    good_step(0); good_step(0);
    check("t2_relock", 32'(lk0), 1);

    // Illegal ring word while locked
    s_j[0] = (s_j[0] + 1) % 4;
    cycle(0, 1'b1, 3, jcode(s_j[0], 2), 1'b0);
    check("t3_ring_ok", 32'(rok0), 0);
    check("t3_err_pulse", 32'(ep0), 1);
    check("t3_err_cnt", 32'(ec0), 2);
    repeat (3) good_step(0);
    check("t3_not_yet_locked", 32'(lk0), 0);
    good_step(0);
    check("t3_relock", 32'(lk0), 1);

    // en=0 gaps with garbage inputs
    for (int n = 1; n <= 5; n++) begin
      repeat (n) cycle(0, 1'b0, $urandom, $urandom, 1'b0);
      good_step(0);
    end
    check("t4_locked", 32'(lk0), 1);
    check("t4_err_cnt", 32'(ec0), 2);

    // Three repeated-code errors bring err_cnt to 5
    repeat (3) begin
      repeat_code(0);
      repeat (3) good_step(0);
    end
    check("t5_pre_err_cnt", 32'(ec0), 5);
    check("t5_pre_locked", 32'(lk0), 1);
    cycle(0, 1'b1, 3, 1, 1'b1);
    check("t5_err_cnt", 32'(ec0), 0);
    check("t5_locked", 32'(lk0), 0);
    check("t5_ring_ok", 32'(rok0), 0);
    check("t5_ring_idx", 32'(ridx0), 0);
    s_r[0] = 1; s_j[0] = 3;
    random_phase(0, 400);

    // WIDTH=4: wrap-around and counter saturation
    cycle(1, 1'b0, 0, 0, 1'b1);
    s_r[1] = 3; s_j[1] = 7;
    repeat (8) good_step(1);
    check("t6_locked", 32'(lk1), 1);
    check("t6_john_idx_7", 32'(jidx1), 7);
    good_step(1);
    check("t6_john_wrap", 32'(jidx1), 0);
    check("t6_ring_wrap", 32'(ridx1), 0);
    check("t6_wrap_locked", 32'(lk1), 1);
    check("t6_wrap_err_cnt", 32'(ec1), 0);
    repeat (300) begin
      repeat_code(1);
      repeat (3) good_step(1);
    end
    check("t6_saturate", 32'(ec1), 255);
    random_phase(1, 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
